// File: rtl/rom_ctrl_rom_sched.sv
// ROM access scheduler: checker owns the ROM after reset, the bus host after
// the checker finishes; responses are routed by a fixed-latency tag pipeline.
module rom_ctrl_rom_sched #(
    parameter int Aw        = 4,
    parameter int Width     = 40,
    parameter int RdLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             chk_req_i,
    input  logic [Aw-1:0]    chk_addr_i,
    input  logic             chk_done_i,
    output logic             chk_gnt_o,
    output logic             chk_rvalid_o,
    output logic [Width-1:0] chk_rdata_o,
    input  logic             bus_req_i,
    input  logic [Aw-1:0]    bus_addr_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [Width-1:0] bus_rdata_o,
    output logic             rom_req_o,
    output logic [Aw-1:0]    rom_addr_o,
    output logic [Aw-1:0]    prince_addr_o,
    input  logic             rom_rvalid_i,
    input  logic [Width-1:0] rom_scr_rdata_i,
    input  logic [Width-1:0] rom_clr_rdata_i,
    output logic             owner_bus_o,
    output logic             alert_o
);

    typedef enum logic [1:0] {
        CheckSt,
        DrainSt,
        BusSt,
        ErrSt
    } state_e;

    typedef struct packed {
        logic vld;
        logic src;
    } tag_t;

    state_e state_q, state_d;
    tag_t   tag_q [RdLatency];
    tag_t   head;
    logic   pipe_empty;
    logic   rsp_mismatch;
    logic   rsp_ok;

    assign head = tag_q[RdLatency-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CheckSt;
            for (int i = 0; i < RdLatency; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tag_q[0] <= '{vld: rom_req_o, src: bus_gnt_o};
            for (int i = 1; i < RdLatency; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < RdLatency; i++) begin
            if (tag_q[i].vld) begin
                pipe_empty = 1'b0;
            end
        end
    end

    // The ROM must answer exactly when the head tag says it will.
    assign rsp_mismatch = rom_rvalid_i != head.vld;

    always_comb begin
        state_d   = state_q;
        chk_gnt_o = 1'b0;
        bus_gnt_o = 1'b0;
        unique case (state_q)
            CheckSt: begin
                chk_gnt_o = chk_req_i;
                if (chk_done_i) begin
                    state_d = DrainSt;
                end
            end
            DrainSt: begin
                if (pipe_empty) begin
                    state_d = BusSt;
                end
            end
            BusSt: begin
                bus_gnt_o = bus_req_i;
            end
            ErrSt: begin
                state_d = ErrSt;
            end
            default: begin
                state_d = ErrSt;
            end
        endcase
        if (rsp_mismatch) begin
            state_d = ErrSt;
        end
        if (rst_i) begin
            chk_gnt_o = 1'b0;
            bus_gnt_o = 1'b0;
        end
    end

    assign rom_req_o = chk_gnt_o | bus_gnt_o;

    always_comb begin
        rom_addr_o = '0;
        if (chk_gnt_o) begin
            rom_addr_o = chk_addr_i;
        end else if (bus_gnt_o) begin
            rom_addr_o = bus_addr_i;
        end
    end

    // Tweak address kept as an independent AND-OR mux of the same source.
    assign prince_addr_o = ({Aw{chk_gnt_o}} & chk_addr_i)
                         | ({Aw{bus_gnt_o}} & bus_addr_i);

    assign rsp_ok = !rst_i && (state_q != ErrSt) && head.vld && rom_rvalid_i;

    assign chk_rvalid_o = rsp_ok && !head.src;
    assign bus_rvalid_o = rsp_ok && head.src;
    assign chk_rdata_o  = chk_rvalid_o ? rom_scr_rdata_i : '0;
    assign bus_rdata_o  = bus_rvalid_o ? rom_clr_rdata_i : '0;

    assign owner_bus_o = !rst_i && (state_q == BusSt);
    assign alert_o     = !rst_i && (state_q == ErrSt);

endmodule
